// File: rtl/craps_engine.sv
// Two-dice craps controller: free-running odometer dice, roll-button edge detect,
// come-out/point game with optional roll limit and saturating win/loss tallies.
module craps_engine #(
    parameter  int SIDES     = 6,
    parameter  int MAX_TRIES = 0,
    parameter  int CNT_W     = 8,
    parameter  int EXT_DICE  = 0,
    localparam int DW        = $clog2(SIDES + 1),
    localparam int SW        = $clog2(2 * SIDES + 1),
    localparam int TW        = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             roll1,
    input  logic             roll2,
    input  logic             new_game,
    input  logic [DW-1:0]    ext_d1,
    input  logic [DW-1:0]    ext_d2,
    output logic [DW-1:0]    die1,
    output logic [DW-1:0]    die2,
    output logic [SW-1:0]    sum,
    output logic [SW-1:0]    point,
    output logic [TW-1:0]    tries_left,
    output logic             rolling,
    output logic             win,
    output logic             lose,
    output logic             done,
    output logic             bad_die,
    output logic [CNT_W-1:0] wins,
    output logic [CNT_W-1:0] losses
);

    typedef enum logic [2:0] {WAIT1, WAIT2, EVAL, WIN, LOSE} state_t;

    state_t           state_r, state_s;
    logic [DW-1:0]    c1_r, c2_r;
    logic             roll1_q_r, roll2_q_r;
    logic             e1_s, e2_s, ok1_s, ok2_s;
    logic [DW-1:0]    cap1_s, cap2_s;
    logic [SW-1:0]    roll_sum_s;
    logic [DW-1:0]    die1_r, die2_r, die1_s, die2_s;
    logic [SW-1:0]    sum_r, point_r, sum_nx_s, point_nx_s;
    logic [TW-1:0]    tries_r, tries_nx_s;
    logic [CNT_W-1:0] wins_r, losses_r, wins_nx_s, losses_nx_s;
    logic             rolling_r, win_r, lose_r, done_r, bad_r, done_s, bad_s;

    function automatic logic die_legal(input logic [DW-1:0] v);
        return (v != {DW{1'b0}}) && (v <= DW'(SIDES));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    assign e1_s       = roll1 & ~roll1_q_r;
    assign e2_s       = roll2 & ~roll2_q_r;
    assign cap1_s     = (EXT_DICE != 0) ? ext_d1 : c1_r;
    assign cap2_s     = (EXT_DICE != 0) ? ext_d2 : c2_r;
    assign ok1_s      = (EXT_DICE != 0) ? die_legal(ext_d1) : 1'b1;
    assign ok2_s      = (EXT_DICE != 0) ? die_legal(ext_d2) : 1'b1;
    assign roll_sum_s = SW'(die1_r) + SW'(die2_r);

    // Game FSM next-state and next-value logic
    always_comb begin
        state_s     = state_r;
        die1_s      = die1_r;
        die2_s      = die2_r;
        sum_nx_s    = sum_r;
        point_nx_s  = point_r;
        tries_nx_s  = tries_r;
        wins_nx_s   = wins_r;
        losses_nx_s = losses_r;
        done_s      = 1'b0;
        bad_s       = 1'b0;
        case (state_r)
            WAIT1: begin
                if (e1_s && ok1_s) begin
                    die1_s  = cap1_s;
                    state_s = WAIT2;
                end else if (e1_s) begin
                    bad_s = 1'b1;
                end else begin
                    state_s = WAIT1;
                end
            end
            WAIT2: begin
                if (e2_s && ok2_s) begin
                    die2_s  = cap2_s;
                    state_s = EVAL;
                end else if (e2_s) begin
                    bad_s = 1'b1;
                end else begin
                    state_s = WAIT2;
                end
            end
            EVAL: begin
                sum_nx_s = roll_sum_s;
                if (point_r == {SW{1'b0}}) begin
                    if ((roll_sum_s == SW'(SIDES + 1)) || (roll_sum_s == SW'(2 * SIDES - 1))) begin
                        state_s   = WIN;
                        wins_nx_s = sat_inc(wins_r);
                        done_s    = 1'b1;
                    end else if ((roll_sum_s == SW'(2)) || (roll_sum_s == SW'(3)) ||
                                 (roll_sum_s == SW'(2 * SIDES))) begin
                        state_s     = LOSE;
                        losses_nx_s = sat_inc(losses_r);
                        done_s      = 1'b1;
                    end else begin
                        point_nx_s = roll_sum_s;
                        tries_nx_s = TW'(MAX_TRIES);
                        state_s    = WAIT1;
                    end
                end else if (roll_sum_s == point_r) begin
                    state_s   = WIN;
                    wins_nx_s = sat_inc(wins_r);
                    done_s    = 1'b1;
                end else if (roll_sum_s == SW'(SIDES + 1)) begin
                    state_s     = LOSE;
                    losses_nx_s = sat_inc(losses_r);
                    done_s      = 1'b1;
                end else if ((MAX_TRIES > 0) && (tries_r <= TW'(1))) begin
                    // last allowed point roll missed
                    tries_nx_s  = {TW{1'b0}};
                    state_s     = LOSE;
                    losses_nx_s = sat_inc(losses_r);
                    done_s      = 1'b1;
                end else if (MAX_TRIES > 0) begin
                    tries_nx_s = tries_r - TW'(1);
                    state_s    = WAIT1;
                end else begin
                    state_s = WAIT1;
                end
            end
            WIN, LOSE: begin
                if (new_game) begin
                    state_s    = WAIT1;
                    die1_s     = {DW{1'b0}};
                    die2_s     = {DW{1'b0}};
                    sum_nx_s   = {SW{1'b0}};
                    point_nx_s = {SW{1'b0}};
                    tries_nx_s = {TW{1'b0}};
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = WAIT1;
            end
        endcase
    end

    // State, dice counters, button history and all registered outputs
    always_ff @(posedge CLK) begin
        roll1_q_r <= roll1;
        roll2_q_r <= roll2;
        if (reset) begin
            state_r   <= WAIT1;
            c1_r      <= DW'(1);
            c2_r      <= DW'(1);
            die1_r    <= {DW{1'b0}};
            die2_r    <= {DW{1'b0}};
            sum_r     <= {SW{1'b0}};
            point_r   <= {SW{1'b0}};
            tries_r   <= {TW{1'b0}};
            wins_r    <= {CNT_W{1'b0}};
            losses_r  <= {CNT_W{1'b0}};
            rolling_r <= 1'b1;
            win_r     <= 1'b0;
            lose_r    <= 1'b0;
            done_r    <= 1'b0;
            bad_r     <= 1'b0;
        end else begin
            c1_r <= (c1_r == DW'(SIDES)) ? DW'(1) : c1_r + DW'(1);
            if (c1_r == DW'(SIDES)) begin
                c2_r <= (c2_r == DW'(SIDES)) ? DW'(1) : c2_r + DW'(1);
            end else begin
                c2_r <= c2_r;
            end
            state_r   <= state_s;
            die1_r    <= die1_s;
            die2_r    <= die2_s;
            sum_r     <= sum_nx_s;
            point_r   <= point_nx_s;
            tries_r   <= tries_nx_s;
            wins_r    <= wins_nx_s;
            losses_r  <= losses_nx_s;
            rolling_r <= (state_s != WIN) && (state_s != LOSE);
            win_r     <= (state_s == WIN);
            lose_r    <= (state_s == LOSE);
            done_r    <= done_s;
            bad_r     <= bad_s;
        end
    end

    assign die1       = die1_r;
    assign die2       = die2_r;
    assign sum        = sum_r;
    assign point      = point_r;
    assign tries_left = tries_r;
    assign rolling    = rolling_r;
    assign win        = win_r;
    assign lose       = lose_r;
    assign done       = done_r;
    assign bad_die    = bad_r;
    assign wins       = wins_r;
    assign losses     = losses_r;

endmodule

// File: tb/tb_craps_engine.sv
// Bench for craps_engine: u1 uses external dice with a 3-roll limit and 2-bit tallies,
// u0 uses the internal odometer dice with no roll limit; both share stimulus.
module tb_craps_engine;
    localparam int S = 6;

    logic CLK = 1'b0;
    logic reset, roll1, roll2, new_game;
    logic [2:0] ext_d1, ext_d2;

    logic [2:0] die1_0, die2_0, die1_1, die2_1;
    logic [3:0] sum_0, point_0, sum_1, point_1;
    logic [0:0] tries_0;
    logic [1:0] tries_1;
    logic       rolling_0, win_0, lose_0, done_0, bad_0;
    logic       rolling_1, win_1, lose_1, done_1, bad_1;
    logic [7:0] wins_0, losses_0;
    logic [1:0] wins_1, losses_1;

    int n_pass = 0;
    int n_total = 0;

    craps_engine #(.SIDES(S), .MAX_TRIES(0), .CNT_W(8), .EXT_DICE(0)) u0 (
        .CLK(CLK), .reset(reset), .roll1(roll1), .roll2(roll2), .new_game(new_game),
        .ext_d1(ext_d1), .ext_d2(ext_d2), .die1(die1_0), .die2(die2_0), .sum(sum_0),
        .point(point_0), .tries_left(tries_0), .rolling(rolling_0), .win(win_0),
        .lose(lose_0), .done(done_0), .bad_die(bad_0), .wins(wins_0), .losses(losses_0));

    craps_engine #(.SIDES(S), .MAX_TRIES(3), .CNT_W(2), .EXT_DICE(1)) u1 (
        .CLK(CLK), .reset(reset), .roll1(roll1), .roll2(roll2), .new_game(new_game),
        .ext_d1(ext_d1), .ext_d2(ext_d2), .die1(die1_1), .die2(die2_1), .sum(sum_1),
        .point(point_1), .tries_left(tries_1), .rolling(rolling_1), .win(win_1),
        .lose(lose_1), .done(done_1), .bad_die(bad_1), .wins(wins_1), .losses(losses_1));

    always #5 CLK = ~CLK;

    // Game model: phase 0 = awaiting first die, 1 = awaiting second die, 2 = scoring, 3 = game over
    int P_EXT[2]  = '{0, 1};
    int P_MT[2]   = '{0, 3};
    int P_CMAX[2] = '{255, 3};
    int m_phase[2], m_d1[2], m_d2[2], m_sum[2], m_point[2], m_tries[2], m_wins[2], m_losses[2];
    bit m_won[2], m_done[2], m_bad[2];
    int m_k;
    bit m_prev1, m_prev2, m_valid = 1'b0;

    task automatic check(string name, int act, int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
    endtask

    task automatic game_over(int i, bit won);
        m_phase[i] = 3;
        m_won[i]   = won;
        m_done[i]  = 1'b1;
        if (won) m_wins[i] = (m_wins[i] < P_CMAX[i]) ? m_wins[i] + 1 : m_wins[i];
        else     m_losses[i] = (m_losses[i] < P_CMAX[i]) ? m_losses[i] + 1 : m_losses[i];
    endtask

    task automatic model_step();
        bit e1, e2;
        int c1, c2, v, s;
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] = 0; m_d1[i] = 0; m_d2[i] = 0; m_sum[i] = 0; m_point[i] = 0;
                m_tries[i] = 0; m_wins[i] = 0; m_losses[i] = 0; m_won[i] = 0;
                m_done[i] = 0; m_bad[i] = 0;
            end
            m_k = 0; m_prev1 = roll1; m_prev2 = roll2; m_valid = 1'b1;
            return;
        end
        e1 = roll1 && !m_prev1;
        e2 = roll2 && !m_prev2;
        c1 = m_k % S + 1;
        c2 = (m_k / S) % S + 1;
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 0; m_bad[i] = 0;
            case (m_phase[i])
                0: if (e1) begin
                    v = P_EXT[i] ? int'(ext_d1) : c1;
                    if (v >= 1 && v <= S) begin m_d1[i] = v; m_phase[i] = 1; end
                    else m_bad[i] = 1;
                end
                1: if (e2) begin
                    v = P_EXT[i] ? int'(ext_d2) : c2;
                    if (v >= 1 && v <= S) begin m_d2[i] = v; m_phase[i] = 2; end
                    else m_bad[i] = 1;
                end
                2: begin
                    s = m_d1[i] + m_d2[i];
                    m_sum[i] = s;
                    m_phase[i] = 0;
                    if (m_point[i] == 0) begin
                        if (s == S + 1 || s == 2 * S - 1) game_over(i, 1);
                        else if (s == 2 || s == 3 || s == 2 * S) game_over(i, 0);
                        else begin m_point[i] = s; m_tries[i] = P_MT[i]; end
                    end else if (s == m_point[i]) game_over(i, 1);
                    else if (s == S + 1) game_over(i, 0);
                    else if (P_MT[i] > 0) begin
                        m_tries[i]--;
                        if (m_tries[i] == 0) game_over(i, 0);
                    end
                end
                default: if (new_game) begin
                    m_phase[i] = 0; m_d1[i] = 0; m_d2[i] = 0; m_sum[i] = 0;
                    m_point[i] = 0; m_tries[i] = 0;
                end
            endcase
        end
        m_k++;
        m_prev1 = roll1;
        m_prev2 = roll2;
    endtask

    task automatic cmp(int i, int d1, int d2, int sm, int pt, int tr, int rl, int wn, int ls,
                       int dn, int bd, int ws, int lo);
        string p;
        p = $sformatf("u%0d.", i);
        check({p, "die1"}, d1, m_d1[i]);
        check({p, "die2"}, d2, m_d2[i]);
        check({p, "sum"}, sm, m_sum[i]);
        check({p, "point"}, pt, m_point[i]);
        check({p, "tries_left"}, tr, m_tries[i]);
        check({p, "rolling"}, rl, int'(m_phase[i] != 3));
        check({p, "win"}, wn, int'(m_phase[i] == 3 && m_won[i]));
        check({p, "lose"}, ls, int'(m_phase[i] == 3 && !m_won[i]));
        check({p, "done"}, dn, int'(m_done[i]));
        check({p, "bad_die"}, bd, int'(m_bad[i]));
        check({p, "wins"}, ws, m_wins[i]);
        check({p, "losses"}, lo, m_losses[i]);
    endtask

    initial forever begin
        @(posedge CLK);
        model_step();
    end

    // Every-cycle comparison of both instances against the model
    initial forever begin
        @(negedge CLK);
        if (m_valid) begin
            cmp(0, int'(die1_0), int'(die2_0), int'(sum_0), int'(point_0), int'(tries_0),
                int'(rolling_0), int'(win_0), int'(lose_0), int'(done_0), int'(bad_0),
                int'(wins_0), int'(losses_0));
            cmp(1, int'(die1_1), int'(die2_1), int'(sum_1), int'(point_1), int'(tries_1),
                int'(rolling_1), int'(win_1), int'(lose_1), int'(done_1), int'(bad_1),
                int'(wins_1), int'(losses_1));
        end
    end

    task automatic tick(int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic press1();
        roll1 = 1'b1; tick(1); roll1 = 1'b0; tick(1);
    endtask

    task automatic press2();
        roll2 = 1'b1; tick(1); roll2 = 1'b0; tick(1);
    endtask

    task automatic roll(int a, int b);
        ext_d1 = 3'(a); ext_d2 = 3'(b);
        press1();
        press2();
        @(negedge CLK);
    endtask

    task automatic ng();
        new_game = 1'b1; tick(1); new_game = 1'b0;
    endtask

    initial begin
        reset = 1'b1; roll1 = 1'b0; roll2 = 1'b0; new_game = 1'b0;
        ext_d1 = 3'd0; ext_d2 = 3'd0;
        tick(2);
        reset = 1'b0;
        @(negedge CLK);
        check("lit reset die1", int'(die1_1), 0);
        check("lit reset rolling", int'(rolling_1), 1);
        check("lit reset u0 die1", int'(die1_0), 0);

        roll(3, 4);
        check("lit t1 sum", int'(sum_1), 7);
        check("lit t1 win", int'(win_1), 1);
        check("lit t1 done", int'(done_1), 1);
        check("lit t1 wins", int'(wins_1), 1);
        tick(1); @(negedge CLK);
        check("lit t1 done pulse", int'(done_1), 0);
        ng();

        roll(1, 1);
        check("lit t2 lose", int'(lose_1), 1);
        check("lit t2 losses", int'(losses_1), 1);
        ng(); @(negedge CLK);
        check("lit t2 rolling", int'(rolling_1), 1);
        check("lit t2 point", int'(point_1), 0);
        check("lit t2 losses kept", int'(losses_1), 1);

        roll(2, 2);
        check("lit t3 point", int'(point_1), 4);
        check("lit t3 tries", int'(tries_1), 3);
        roll(2, 3);
        check("lit t3 tries2", int'(tries_1), 2);
        roll(1, 5);
        check("lit t3 tries1", int'(tries_1), 1);
        roll(6, 6);
        check("lit t3 lose", int'(lose_1), 1);
        check("lit t3 tries0", int'(tries_1), 0);
        ng();

        roll(2, 2);
        roll(3, 4);
        check("lit t4 seven-out", int'(lose_1), 1);
        check("lit t4 losses sat", int'(losses_1), 3);
        ng();
        roll(2, 2);
        roll(1, 3);
        check("lit t4 point win", int'(win_1), 1);
        check("lit t4 wins", int'(wins_1), 2);
        ng();

        ext_d1 = 3'd7;
        roll1 = 1'b1; tick(1); @(negedge CLK);
        check("lit t5 bad_die", int'(bad_1), 1);
        check("lit t5 die1 kept", int'(die1_1), 0);
        roll1 = 1'b0; tick(1); @(negedge CLK);
        check("lit t5 bad pulse", int'(bad_1), 0);
        ext_d1 = 3'd0; press1();
        ext_d1 = 3'd5; ext_d2 = 3'd2;
        roll1 = 1'b1; roll2 = 1'b1; tick(1);
        roll1 = 1'b0; roll2 = 1'b0; tick(1); @(negedge CLK);
        check("lit t5 sim die1", int'(die1_1), 5);
        check("lit t5 sim die2", int'(die2_1), 0);
        ext_d2 = 3'd0; press2();
        ext_d2 = 3'd2; press2(); @(negedge CLK);
        check("lit t5 sum", int'(sum_1), 7);
        check("lit t5 wins", int'(wins_1), 3);
        ng();
        roll(5, 6);
        check("lit t6 win11", int'(win_1), 1);
        check("lit t6 wins sat", int'(wins_1), 3);
        ng();

        roll1 = 1'b1; reset = 1'b1; tick(2);
        reset = 1'b0; tick(3); @(negedge CLK);
        check("lit t6 held die1", int'(die1_1), 0);
        check("lit t6 held u0 die1", int'(die1_0), 0);
        roll1 = 1'b0; tick(1);
        roll(2, 2);
        check("lit t6 point", int'(point_1), 4);
        reset = 1'b1; tick(1); reset = 1'b0; @(negedge CLK);
        check("lit t6 rst point", int'(point_1), 0);
        check("lit t6 rst tries", int'(tries_1), 0);
        check("lit t6 rst wins", int'(wins_1), 0);
        check("lit t6 rst die1", int'(die1_1), 0);
        check("lit t6 rst rolling", int'(rolling_1), 1);

        // Extra internal-dice traffic so u0 plays several more games
        for (int r = 0; r < 40; r++) begin
            roll(1 + r % 6, 1 + (r * 5) % 6);
            if (!rolling_1 || !rolling_0) ng();
        end
        tick(2);
        @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
